mem_port_arbiter: RTL

- Owns the single memory port and shares it between the external loader/debug port (ext) and the CPU fetch/decode path (cpu).
- Holds the CPU in reset while ext loads the program, then releases it and pulses the start strobe that drives fetcher get_next.
- In run mode, lends the memory back to ext only at instruction boundaries by stalling the CPU.
- Replaces the ad-hoc manual_mem muxing; lets memory be filled while the CPU is held in reset.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - state encodings and default sizes for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_REG_WIDTH  = 8;
  localparam int DEF_RESET_HOLD = 2;
  localparam int DEF_DRAIN_MAX  = 16;
  localparam int CNT_WIDTH      = 8;

  typedef enum logic [2:0] {
    ARB_LOAD    = 3'd0,
    ARB_RELEASE = 3'd1,
    ARB_START   = 3'd2,
    ARB_RUN     = 3'd3,
    ARB_DRAIN   = 3'd4,
    ARB_EXT     = 3'd5
  } arb_state_t;

  function automatic logic ext_owns(input arb_state_t s);
    return (s == ARB_LOAD) || (s == ARB_EXT);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - loader/debug side of the shared memory port
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_REG_WIDTH
);

  logic                  load_done;
  logic                  ext_req;
  logic                  ext_we;
  logic [ADDR_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_din;
  logic                  ext_gnt;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  ext_rvalid;

  modport master (
    output load_done, ext_req, ext_we, ext_addr, ext_din,
    input  ext_gnt, ext_rdata, ext_rvalid
  );

  modport slave (
    input  load_done, ext_req, ext_we, ext_addr, ext_din,
    output ext_gnt, ext_rdata, ext_rvalid
  );

endinterface

// File: rtl/mem_port_arbiter_counter.sv
// rtl/mem_port_arbiter_counter.sv - loadable down-counter with zero flag, shared by reset hold and drain wait
module arb_down_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the memory port between the ext loader and the CPU fetch path
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_REG_WIDTH,
  parameter int RESET_HOLD = DEF_RESET_HOLD,
  parameter int DRAIN_MAX  = DEF_DRAIN_MAX
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_port_arbiter_if.slave     ext,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  input  logic                  cpu_instr_done,
  output logic                  cpu_stall,
  output logic                  cpu_reset_n,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  err_timeout
);

  localparam logic [CNT_WIDTH-1:0] HOLD_INIT  = CNT_WIDTH'(RESET_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_INIT = CNT_WIDTH'(DRAIN_MAX - 1);

  arb_state_t           state, next_state;
  logic                 timeout_hit;
  logic                 cnt_load, cnt_en, cnt_zero;
  logic [CNT_WIDTH-1:0] cnt_value;
  logic                 ext_owner;
  logic                 handover_now;
  logic                 rvalid_q, cpu_reset_q, err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_LOAD;
    end else begin
      state <= next_state;
    end
  end

  // In DRAIN a dropped request wins over a boundary, which wins over the timeout.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      ARB_LOAD:    if (ext.load_done && !ext.ext_req) next_state = ARB_RELEASE;
      ARB_RELEASE: if (cnt_zero) next_state = ARB_START;
      ARB_START:   next_state = ARB_RUN;
      ARB_RUN:     if (ext.ext_req) next_state = cpu_instr_done ? ARB_EXT : ARB_DRAIN;
      ARB_DRAIN: begin
        if (!ext.ext_req) begin
          next_state = ARB_RUN;
        end else if (cpu_instr_done) begin
          next_state = ARB_EXT;
        end else if (cnt_zero) begin
          next_state  = ARB_EXT;
          timeout_hit = 1'b1;
        end
      end
      ARB_EXT:     if (!ext.ext_req) next_state = ARB_RUN;
      default:     next_state = ARB_LOAD;
    endcase
  end

  assign cnt_load  = (next_state != state) &&
                     ((next_state == ARB_RELEASE) || (next_state == ARB_DRAIN));
  assign cnt_value = (next_state == ARB_RELEASE) ? HOLD_INIT : DRAIN_INIT;
  assign cnt_en    = (state == ARB_RELEASE) || (state == ARB_DRAIN);

  arb_down_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (cnt_value),
    .en         (cnt_en),
    .zero       (cnt_zero)
  );

  assign ext_owner = ext_owns(state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q    <= 1'b0;
      cpu_reset_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rvalid_q    <= ext.ext_req && ext_owner && !ext.ext_we;
      cpu_reset_q <= (next_state != ARB_LOAD) && (next_state != ARB_RELEASE);
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  // Select comes only from the registered state, so the port never glitches between owners.
  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = cpu_din;
    mem_we   = 1'b0;
    case (state)
      ARB_LOAD, ARB_EXT: begin
        mem_addr = ext.ext_addr;
        mem_din  = ext.ext_din;
        mem_we   = ext.ext_req && ext.ext_we;
      end
      ARB_START, ARB_RUN, ARB_DRAIN: mem_we = cpu_we;
      default: mem_we = 1'b0;
    endcase
  end

  assign handover_now = ((state == ARB_RUN) || (state == ARB_DRAIN)) &&
                        ext.ext_req && cpu_instr_done;

  assign cpu_stall      = ext_owner || (state == ARB_RELEASE) || handover_now;
  assign cpu_start      = (state == ARB_START);
  assign cpu_reset_n    = cpu_reset_q;
  assign err_timeout    = err_q;
  assign ext.ext_gnt    = ext_owner;
  assign ext.ext_rdata  = mem_dout;
  assign ext.ext_rvalid = rvalid_q;

endmodule
